// File: rtl/gray_stream_checker.sv
// Gray-coded stream consumer: decodes each accepted word to binary through a
// single registered output slot and checks that successive words form a legal
// +1 / -1 counting sequence (mod 2^WIDTH), counting any step violations.
module gray_stream_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    output logic                 gray_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    output logic                 locked,
    output logic                 dir,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_FIRST    = 2'd1,
        ST_LOCK_UP  = 2'd2,
        ST_LOCK_DN  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]     STEP_ZERO = '0;
    localparam logic [WIDTH-1:0]     STEP_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     STEP_DN   = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     bin_q;
    logic                 bin_valid_q;
    logic                 step_err_q, step_err_d;
    logic                 locked_q;
    logic                 dir_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 accept_c;
    logic                 err_c;
    logic [WIDTH-1:0]     bin_c;
    logic [WIDTH-1:0]     delta_c;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Slot can take a word when empty or being drained; held off during reset.
    assign gray_ready = rst_n & (~bin_valid_q | bin_ready);
    assign accept_c   = gray_valid & gray_ready;
    assign bin_c      = gray2bin(gray_in);
    assign delta_c    = bin_c - prev_q;

    // Next lock state, step error and error count for the current cycle.
    always_comb begin
        state_d = state_q;
        err_c   = 1'b0;
        if (accept_c) begin
            case (state_q)
                ST_UNLOCKED: state_d = ST_FIRST;
                ST_FIRST: begin
                    if (delta_c == STEP_UP) begin
                        state_d = ST_LOCK_UP;
                    end else if (delta_c == STEP_DN) begin
                        state_d = ST_LOCK_DN;
                    end else if (delta_c != STEP_ZERO) begin
                        err_c = 1'b1;
                    end
                end
                ST_LOCK_UP: begin
                    if (delta_c != STEP_UP && delta_c != STEP_ZERO) begin
                        err_c   = 1'b1;
                        state_d = ST_FIRST;
                    end
                end
                ST_LOCK_DN: begin
                    if (delta_c != STEP_DN && delta_c != STEP_ZERO) begin
                        err_c   = 1'b1;
                        state_d = ST_FIRST;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
        // Clear restarts tracking; an accepted word in the same cycle seeds FIRST.
        if (clr) begin
            state_d = accept_c ? ST_FIRST : ST_UNLOCKED;
        end
        step_err_d = err_c & ~clr;
        if (clr) begin
            err_cnt_d = '0;
        end else if (step_err_d && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, output slot and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            prev_q      <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            dir_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= (state_d == ST_LOCK_UP) || (state_d == ST_LOCK_DN);
            dir_q       <= (state_d == ST_LOCK_UP);
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
            bin_valid_q <= accept_c | (bin_valid_q & ~bin_ready);
            if (accept_c) begin
                prev_q <= bin_c;
                bin_q  <= bin_c;
            end
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign step_err  = step_err_q;
    assign locked    = locked_q;
    assign dir       = dir_q;
    assign err_count = err_cnt_q;

endmodule
